// File: rtl/xunit_stream_driver_pkg.sv
// Shared types and constants for the xunit stream driver: FSM states, default
// geometry and index/counter width helpers.
package xunit_stream_driver_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_N_WORDS    = 16;
    localparam int DEF_FU_LATENCY = 17;
    localparam int LAT_W          = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xunit_stream_buf.sv
// N_WORDS x DATA_W word buffer: one synchronous write port, one asynchronous read port.
module xunit_stream_buf
    import xunit_stream_driver_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_N_WORDS,
    localparam int AW     = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/xunit_stream_driver.sv
// Streams a loaded word buffer through a functional unit and captures its results.
// Optional result checking against an expected buffer: XUNIT_STREAM_DRIVER_CHECK_EN.
//
// state    | meaning
// S_IDLE   | buffers writable, waiting for start
// S_PULSE  | one-cycle fu_run pulse (T0)
// S_STREAM | presenting in_buf words on fu_in0
// S_DRAIN  | inputs done, waiting for remaining captures
// S_DONE   | one-cycle done pulse
module xunit_stream_driver
    import xunit_stream_driver_pkg::*;
#(
    parameter  int DATA_W     = DEF_DATA_W,
    parameter  int N_WORDS    = DEF_N_WORDS,
    parameter  int FU_LATENCY = DEF_FU_LATENCY,
    localparam int AW         = idx_w(N_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [7:0]        delay_cfg,
    output logic              busy,
    output logic              done,
    output logic              fu_run,
    output logic [7:0]        fu_delay,
    output logic [DATA_W-1:0] fu_in0,
    input  logic [DATA_W-1:0] fu_out0,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       err_cnt
);

    state_t            state, state_nxt;
    logic [AW-1:0]     str_idx, cap_idx;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] in_rd;
    logic              accept, running, cap_en, str_last, cap_last;

    assign accept   = (state == S_IDLE) && start;
    assign running  = (state == S_STREAM) || (state == S_DRAIN);
    assign cap_en   = running && (lat_cnt == '0);
    assign str_last = (state == S_STREAM) && (str_idx == AW'(N_WORDS - 1));
    assign cap_last = cap_en && (cap_idx == AW'(N_WORDS - 1));

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign fu_run = (state == S_PULSE);
    assign fu_in0 = (state == S_STREAM) ? in_rd : '0;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_PULSE;
            S_PULSE:  state_nxt = S_STREAM;
            S_STREAM: if (str_last) state_nxt = cap_last ? S_DONE : S_DRAIN;
            S_DRAIN:  if (cap_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // lat_cnt holds during PULSE so it first counts in T0+1; captures begin once it reaches zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            fu_delay <= '0;
            lat_cnt  <= '0;
            str_idx  <= '0;
            cap_idx  <= '0;
        end else begin
            if (accept) begin
                fu_delay <= delay_cfg;
                lat_cnt  <= {1'b0, delay_cfg} + LAT_W'(FU_LATENCY);
                str_idx  <= '0;
                cap_idx  <= '0;
            end
            if (state == S_STREAM) str_idx <= str_idx + 1'b1;
            if (running && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
            if (cap_en) cap_idx <= cap_idx + 1'b1;
        end
    end

    xunit_stream_buf #(.DATA_W(DATA_W), .DEPTH(N_WORDS)) u_in_buf (
        .clk   (clk),
        .we    (wr_en && !busy && !wr_sel),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (str_idx),
        .rdata (in_rd)
    );

    xunit_stream_buf #(.DATA_W(DATA_W), .DEPTH(N_WORDS)) u_out_buf (
        .clk   (clk),
        .we    (cap_en && rst),
        .waddr (cap_idx),
        .wdata (fu_out0),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

`ifdef XUNIT_STREAM_DRIVER_CHECK_EN
    logic [DATA_W-1:0] exp_rd;

    xunit_stream_buf #(.DATA_W(DATA_W), .DEPTH(N_WORDS)) u_exp_buf (
        .clk   (clk),
        .we    (wr_en && !busy && wr_sel),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (cap_idx),
        .rdata (exp_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (accept) begin
            err_cnt <= '0;
        end else if (cap_en && fu_out0 != exp_rd && err_cnt != (AW+1)'(N_WORDS)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_xunit_stream_driver.sv
// Directed bench for xunit_stream_driver with a delay-line loopback FU model.
module tb_xunit_stream_driver;

    localparam int DW = 32;
    localparam int NW = 16;
    localparam int AW = 4;

`ifdef XUNIT_STREAM_DRIVER_CHECK_EN
    localparam int ERR_ONE = 1;
    localparam int ERR_ALL = 16;
`else
    localparam int ERR_ONE = 0;
    localparam int ERR_ALL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [7:0]    delay_cfg = '0;
    logic          busy, done, fu_run;
    logic [7:0]    fu_delay;
    logic [DW-1:0] fu_in0, fu_out0, rd_data;
    logic [AW-1:0] rd_addr = '0;
    logic [AW:0]   err_cnt;

    int            total = 0;
    int            bad = 0;
    int            tb_lat = 17;
    logic [DW-1:0] in_exp [NW];
    logic [DW-1:0] hist [0:511];

    xunit_stream_driver #(.DATA_W(DW), .N_WORDS(NW), .FU_LATENCY(17)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .delay_cfg (delay_cfg),
        .busy      (busy),
        .done      (done),
        .fu_run    (fu_run),
        .fu_delay  (fu_delay),
        .fu_in0    (fu_in0),
        .fu_out0   (fu_out0),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // FU model: output in cycle c is the input from cycle c - tb_lat
    always @(posedge clk) begin
        for (int i = 511; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= fu_in0;
    end
    assign fu_out0 = hist[tb_lat-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = a[AW-1:0];
        wr_data = d;
        step();
        wr_en  = 1'b0;
        wr_sel = 1'b0;
    endtask

    task automatic readout(input string tag);
        for (int i = 0; i < NW; i++) begin
            rd_addr = i[AW-1:0];
            #1;
            chk($sformatf("%s_rd%0d", tag, i), rd_data, in_exp[i]);
        end
    endtask

    task automatic run(input logic [7:0] dly, input int done_at, input logic poke, input string tag);
        int done_cnt;
        int done_k;
        done_cnt  = 0;
        done_k    = -1;
        tb_lat    = int'(dly) + 17;
        delay_cfg = dly;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_run_t0"}, fu_run, 1);
        chk({tag, "_busy_t0"}, busy, 1);
        for (int k = 1; k <= done_at + 3; k++) begin
            step();
            if (poke && k == 6) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (poke && k == done_k + 1 && done_k > 0) begin
                chk({tag, "_start_at_done"}, busy, 0);
                start = 1'b0;
            end
            if (k == 1) chk({tag, "_run_k1"}, fu_run, 0);
            if (k <= NW) chk($sformatf("%s_in%0d", tag, k - 1), fu_in0, in_exp[k-1]);
            if (k == NW + 1) chk({tag, "_in_idle"}, fu_in0, 0);
            if (done_k > 0 && k == done_k + 1) chk({tag, "_busy_after"}, busy, 0);
            if (done === 1'b1) begin
                done_cnt++;
                done_k = k;
                if (poke) start = 1'b1;
            end
            if (poke && k == 5) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 4'd12;
                wr_data = 32'h0000_0BAD;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        chk({tag, "_done_cycle"}, done_k, done_at);
        chk({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        int dcnt;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_run", fu_run, 0);
        chk("rst_in0", fu_in0, 0);
        chk("rst_delay", fu_delay, 0);
        chk("rst_err", err_cnt, 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < NW; i++) begin
            in_exp[i] = DW'(i + 1);
            wr(1'b0, i, in_exp[i]);
            wr(1'b1, i, in_exp[i]);
        end
        run(8'd0, 34, 1'b0, "base");
        chk("base_delay", fu_delay, 0);
        chk("base_err", err_cnt, 0);
        readout("base");

        run(8'd0, 34, 1'b1, "poke");
        readout("poke");

        wr(1'b1, 5, 32'hDEAD_BEEF);
        run(8'd0, 34, 1'b0, "bad1");
        chk("bad1_err", err_cnt, ERR_ONE);
        for (int i = 0; i < NW; i++) wr(1'b1, i, 32'hDEAD_BEEF);
        run(8'd0, 34, 1'b0, "bad16");
        chk("bad16_err", err_cnt, ERR_ALL);
        readout("bad16");

        for (int i = 0; i < NW; i++) begin
            in_exp[i] = 32'h100 + DW'(i * 3);
            wr(1'b0, i, in_exp[i]);
            wr(1'b1, i, in_exp[i]);
        end
        run(8'd255, 289, 1'b0, "d255");
        chk("d255_delay", fu_delay, 255);
        chk("d255_err", err_cnt, 0);
        readout("d255");

        delay_cfg = 8'd0;
        tb_lat    = 17;
        start     = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        rst = 1'b0;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_in0", fu_in0, 0);
        chk("abort_done", done, 0);
        chk("abort_run", fu_run, 0);
        rst  = 1'b1;
        dcnt = 0;
        repeat (40) begin
            step();
            if (done === 1'b1) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);

        run(8'd0, 34, 1'b0, "fresh");
        chk("fresh_err", err_cnt, 0);
        readout("fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xunit_stream_driver.md
XUNIT_STREAM_DRIVER -- requirements
Module: xunit_stream_driver

Interface
REQ-001 SHALL have parameter DATA_W, default 32, FU data word width.
REQ-002 SHALL have parameter N_WORDS, default 16, words per stream (power of 2).
REQ-003 SHALL have parameter FU_LATENCY, default 17, intrinsic FU latency in cycles.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-low reset.
REQ-005 SHALL have ports: wr_en  in  1  buffer write; wr_sel  in  1  0=input buffer, 1=expected buffer; wr_addr  in  log2(N_WORDS)  word index; wr_data  in  DATA_W  word.
REQ-006 SHALL have ports: start  in  1  begin stream; delay_cfg  in  8  extra FU delay; busy  out  1  run in progress; done  out  1  one-cycle completion pulse.
REQ-007 SHALL have ports: fu_run  out  1  FU run pulse; fu_delay  out  8  FU delay config; fu_in0  out  DATA_W  FU input; fu_out0  in  DATA_W  FU output.
REQ-008 SHALL have ports: rd_addr  in  log2(N_WORDS)  result index; rd_data  out  DATA_W  captured result (combinational read); err_cnt  out  log2(N_WORDS)+1  mismatch count.

Function
REQ-009 SHALL implement FSM IDLE -> PULSE -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-010 IDLE: start=1 SHALL latch delay_cfg into fu_delay, clear err_cnt and go to PULSE; start outside IDLE SHALL be ignored.
REQ-011 PULSE (cycle T0): fu_run SHALL be 1 for exactly this cycle; next state STREAM.
REQ-012 STREAM: fu_in0 SHALL equal in_buf[i] during cycle T0+1+i, i=0..N_WORDS-1; fu_in0 SHALL be 0 in all other cycles.
REQ-013 Capture: fu_out0 SHALL be written into out_buf[j] at the clock edge ending cycle T0+1+fu_delay+FU_LATENCY+j, j=0..N_WORDS-1; capture counter independent of STREAM progress.
REQ-014 STREAM SHALL go to DRAIN after the last input word; DRAIN SHALL go to DONE on the edge capturing word N_WORDS-1 (may coincide with STREAM end when fu_delay+FU_LATENCY=0... STREAM SHALL then go directly to DONE).
REQ-015 DONE SHALL assert done for one cycle and return to IDLE.
REQ-016 busy SHALL be 1 in PULSE, STREAM, DRAIN, DONE; 0 in IDLE.
REQ-017 wr_en while busy=1 SHALL be ignored; wr_en in IDLE SHALL write the selected buffer at wr_addr.
REQ-018 Latency counter SHALL be 9 bits, loaded with fu_delay+FU_LATENCY (no overflow for delay_cfg=255).
REQ-019 Start in same cycle as done SHALL be ignored (FSM not in IDLE).

Reset
REQ-020 rst=0 at a clock edge SHALL force IDLE, busy=0, done=0, fu_run=0, fu_in0=0, fu_delay=0, err_cnt=0, counters=0.
REQ-021 Reset SHALL NOT clear in_buf, exp_buf or out_buf contents; reset mid-stream SHALL abort with no done pulse.

Configuration
REQ-022 With XUNIT_STREAM_DRIVER_CHECK_EN defined: exp_buf present; each captured word SHALL be compared with exp_buf[j] and err_cnt incremented on mismatch, saturating at N_WORDS.
REQ-023 Without XUNIT_STREAM_DRIVER_CHECK_EN: exp_buf absent, wr_sel=1 writes ignored, err_cnt tied to 0.

Structure
REQ-024 Shared package SHALL hold FSM state typedef, default DATA_W/N_WORDS/FU_LATENCY constants, and counter width derivation.
REQ-025 One sub-module xunit_stream_buf (single write port, single async read port, N_WORDS x DATA_W) SHALL be instantiated for in_buf, out_buf and, when enabled, exp_buf.

Verification
REQ-026 Load in_buf[i]=i+1, loopback FU model (latency 17, delay 0), start -> fu_run high at T0, fu_in0=1..16 at T0+1..T0+16, out_buf[i]=i+1, done at T0+34, err_cnt=0.
REQ-027 CHECK_EN, exp_buf[5] corrupted to 0xDEADBEEF, same run -> err_cnt=1; all 16 corrupted -> err_cnt=16.
REQ-028 delay_cfg=255 -> first capture at T0+273, done at T0+289, no counter wrap.
REQ-029 Pull rst=0 at T0+8 -> busy=0 next cycle, no done pulse, fu_in0=0; fresh start then completes normally.
REQ-030 start and wr_en pulsed while busy -> ignored; in_buf unchanged, single done pulse.
